// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// Holds the FSM state enum, default sizing and a counter-width helper.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_BURST  = 8;

    // Beat counter must be able to hold MAX_BURST itself.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after ptr, wrapping.
// Ports: req (request vector), ptr (start index), idx (winner), found.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    localparam int SW = ID_W + 1;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      off;
    logic [SW-1:0]        sum;

    always_comb begin
        // Rotate so bit k of rot is requester (ptr+k) mod NUM_REQ.
        dbl   = {req, req} >> ptr;
        rot   = dbl[NUM_REQ-1:0];
        off   = '0;
        found = 1'b0;
        // Scan downward so the smallest offset is the final winner.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = ID_W'(k);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SW'(NUM_REQ)) begin
            sum = sum - SW'(NUM_REQ);
        end
        idx = sum[ID_W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ beat streams into one sync FIFO.
// Ports: clk, rst (sync, active-high); req_valid/req_data/req_last in,
// req_ready out; fifo_wr_en/fifo_din out (registered), fifo_prog_full
// in; grant_id (current holder) and busy (in BURST) status outputs.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_prog_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(MAX_BURST);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_found;
    logic [ID_W-1:0]   id_nxt;
    logic              xfer;
    logic              burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign xfer = (state == BURST) && !fifo_prog_full
                  && req_valid[grant_id];

    assign cnt_nxt   = beat_cnt + CNT_W'(1);
    assign burst_end = req_last[grant_id]
                       || (cnt_nxt == CNT_W'(MAX_BURST));

    assign id_nxt = (grant_id == ID_W'(NUM_REQ - 1))
                    ? '0 : grant_id + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (state == BURST && !fifo_prog_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    // A dropped valid or prog_full simply means no
                    // transfer; the grant is held until a real exit.
                    if (xfer) begin
                        beat_cnt <= cnt_nxt;
                        if (burst_end) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= id_nxt;
                        end
                    end
                end
            endcase
        end
    end

    // One-cycle write pipeline; the FIFO threshold covers this beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
        end else begin
            fifo_wr_en <= xfer;
            if (xfer) begin
                fifo_din <= req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Requester sources are modelled as beat counters; writes are logged.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic            fifo_prog_full;
    logic [1:0]      grant_id;
    logic            busy;

    int n_chk;
    int n_err;
    int cyc;

    logic [31:0] src_base [N];
    int          src_b    [N];
    int          src_left [N];
    int          src_plen [N];
    logic [N-1:0] mute;

    logic [31:0] wr_q [$];
    int          wr_t [$];

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_din       (fifo_din),
        .fifo_prog_full (fifo_prog_full),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (src_left[i] != 0) && !mute[i];
            req_data[i*DW +: DW] = src_base[i] + 32'(src_b[i]);
            req_last[i] = (src_b[i] % src_plen[i]) == src_plen[i] - 1;
        end
    endtask

    task automatic step();
        logic [N-1:0] fire;
        @(negedge clk);
        fire = req_valid & req_ready;
        if (fifo_wr_en === 1'b1) begin
            wr_q.push_back(fifo_din);
            wr_t.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                src_b[i]++;
                src_left[i]--;
            end
        end
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_base[i] = '0;
            src_b[i]    = 0;
            src_left[i] = 0;
            src_plen[i] = 1;
        end
        mute = '0;
        drive();
    endtask

    task automatic load(input int i, input logic [31:0] base,
                        input int len, input int plen);
        src_base[i] = base;
        src_b[i]    = 0;
        src_left[i] = len;
        src_plen[i] = plen;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_src();
        wr_q.delete();
        wr_t.delete();
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < N; i++) begin
            if (src_left[i] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int max);
        int k;
        k = 0;
        while (k < max && !(srcs_empty() && busy === 1'b0
                            && fifo_wr_en === 1'b0)) begin
            step();
            k++;
        end
        chk({tag, " drained"}, 32'(k < max), 32'd1);
    endtask

    task automatic check_log(input string tag, input logic [31:0] exp[$]);
        chk({tag, " count"}, 32'(wr_q.size()), 32'(exp.size()));
        for (int j = 0; j < exp.size() && j < wr_q.size(); j++) begin
            chk($sformatf("%s[%0d]", tag, j), wr_q[j], exp[j]);
        end
    endtask

    initial begin
        logic [31:0] exp_q [$];
        int runs [$];
        int v;
        int r;

        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b1;
        fifo_prog_full = 1'b0;
        clear_src();

        // Reset state
        step();
        step();
        step();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst din", fifo_din, 32'd0);
        chk("rst grant", 32'(grant_id), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Single requester, 3-beat packet
        do_reset();
        load(0, 32'hA1, 3, 3);
        drive();
        v = cyc;
        #1;
        chk("idle ready", 32'(req_ready), 32'd0);
        wait_idle("single", 20);
        exp_q = '{32'hA1, 32'hA2, 32'hA3};
        check_log("single", exp_q);
        if (wr_t.size() == 3) begin
            chk("single t0", 32'(wr_t[0]), 32'(v + 2));
            chk("single t1", 32'(wr_t[1]), 32'(v + 3));
            chk("single t2", 32'(wr_t[2]), 32'(v + 4));
        end
        chk("single busy", 32'(busy), 32'd0);
        chk("single hold din", fifo_din, 32'hA3);

        // Four requesters, 1-beat packets, round-robin
        do_reset();
        load(0, 32'h100, 2, 1);
        load(1, 32'h200, 2, 1);
        load(2, 32'h300, 1, 1);
        load(3, 32'h400, 1, 1);
        drive();
        wait_idle("rr", 40);
        exp_q = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h101, 32'h201};
        check_log("rr", exp_q);
        for (int j = 1; j < wr_t.size(); j++) begin
            chk($sformatf("rr gap%0d", j), 32'(wr_t[j] - wr_t[j-1]), 32'd2);
        end

        // 20-beat packet split into 8/8/4
        do_reset();
        load(1, 32'h1000, 20, 20);
        drive();
        wait_idle("split", 100);
        exp_q.delete();
        for (int j = 0; j < 20; j++) exp_q.push_back(32'h1000 + 32'(j));
        check_log("split", exp_q);
        runs.delete();
        r = 1;
        for (int j = 1; j < wr_t.size(); j++) begin
            if (wr_t[j] == wr_t[j-1] + 1) begin
                r++;
            end else begin
                runs.push_back(r);
                r = 1;
            end
        end
        runs.push_back(r);
        chk("split runs", 32'(runs.size()), 32'd3);
        if (runs.size() == 3) begin
            chk("split run0", 32'(runs[0]), 32'd8);
            chk("split run1", 32'(runs[1]), 32'd8);
            chk("split run2", 32'(runs[2]), 32'd4);
        end

        // Continuation re-arbitrates against a late requester
        do_reset();
        load(1, 32'h2000, 20, 20);
        drive();
        for (int j = 0; j < 9; j++) step();
        #1;
        chk("rearb idle", 32'(busy), 32'd0);
        load(2, 32'h3000, 1, 1);
        drive();
        wait_idle("rearb", 100);
        exp_q.delete();
        for (int j = 0; j < 8; j++) exp_q.push_back(32'h2000 + 32'(j));
        exp_q.push_back(32'h3000);
        for (int j = 8; j < 20; j++) exp_q.push_back(32'h2000 + 32'(j));
        check_log("rearb", exp_q);

        // prog_full stall for 5 cycles after beat 3
        do_reset();
        load(0, 32'h4000, 6, 6);
        drive();
        for (int j = 0; j < 4; j++) step();
        fifo_prog_full = 1'b1;
        #1;
        chk("stall ready0", 32'(req_ready), 32'd0);
        for (int s = 0; s < 5; s++) begin
            step();
            #1;
            chk($sformatf("stall ready%0d", s + 1), 32'(req_ready), 32'd0);
            chk($sformatf("stall busy%0d", s + 1), 32'(busy), 32'd1);
            if (s == 0) chk("stall log a", 32'(wr_q.size()), 32'd3);
        end
        chk("stall log b", 32'(wr_q.size()), 32'd3);
        fifo_prog_full = 1'b0;
        wait_idle("stall", 40);
        exp_q.delete();
        for (int j = 0; j < 6; j++) exp_q.push_back(32'h4000 + 32'(j));
        check_log("stall", exp_q);

        // Reset mid-burst; rr_ptr is 1 here from the previous grant
        clear_src();
        wr_q.delete();
        wr_t.delete();
        load(2, 32'h5000, 4, 4);
        drive();
        step();
        step();
        #1;
        chk("abort grant", 32'(grant_id), 32'd2);
        rst = 1'b1;
        step();
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort wr_en", 32'(fifo_wr_en), 32'd0);
        chk("abort din", fifo_din, 32'd0);
        chk("abort ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        clear_src();
        load(0, 32'h6000, 1, 1);
        load(1, 32'h7000, 1, 1);
        drive();
        wait_idle("abort", 40);
        exp_q = '{32'h5000, 32'h6000, 32'h7000};
        check_log("abort", exp_q);

        // Granted requester drops valid mid-burst
        do_reset();
        load(0, 32'h8000, 4, 4);
        load(1, 32'h9000, 1, 1);
        load(3, 32'hB000, 1, 1);
        drive();
        step();
        step();
        step();
        mute[0] = 1'b1;
        drive();
        for (int s = 0; s < 3; s++) begin
            step();
            #1;
            chk($sformatf("hold grant%0d", s), 32'(grant_id), 32'd0);
            chk($sformatf("hold busy%0d", s), 32'(busy), 32'd1);
        end
        mute[0] = 1'b0;
        drive();
        wait_idle("hold", 40);
        exp_q = '{32'h8000, 32'h8001, 32'h8002, 32'h8003,
                  32'h9000, 32'hB000};
        check_log("hold", exp_q);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
